cache_control_fsm: RTL and testbench
====================================

Name: cache_control_fsm

Overview:
- Sequencing controller for the 2-way, 8-set, 256-bit-line cache datapath.
- Takes the CPU-side read/write request and the datapath hit, miss and dirty status.
- Drives the datapath load/select strobes and the physical-memory read/write handshake.
- Sits between the CPU memory port and the cache datapath, one instance per cache.

Parameters:
CNT_W, 32, width of the optional performance counters

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset (asserted at 0, released synchronously to clk)
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_resp  out  1  one-cycle completion pulse to CPU
hit_overall  in  1  datapath hit (valid only while in_compare_tag=1)
miss_overall  in  1  datapath miss
dirty_overall  in  1  dirty bit of the LRU way
in_compare_tag  out  1  enables datapath tag compare
load_tag  out  1  tag array write strobe
load_valid  out  1  valid array write strobe
load_dirty  out  1  dirty array write strobe
load_data  out  1  data array write strobe
data_in_sel  out  1  0 = CPU write data, 1 = pmem refill data
write_back_state  out  1  1 = pmem address from victim tag
pmem_read  out  1  physical memory read request
pmem_write  out  1  physical memory write request
pmem_resp  in  1  physical memory completion
hit_count  out  CNT_W  hits (optional feature)
miss_count  out  CNT_W  misses (optional feature)
wb_count  out  CNT_W  writebacks (optional feature)

Behaviour:
- States: S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE. Register `refill` flags a re-compare after allocate.
- Valid request: req = mem_read XOR mem_write. Both high or both low counts as no request.
- All outputs are Moore-decoded from state, plus the COMPARE-cycle hit/write qualifiers below.
- Reset (rst=0, any time, including mid-pmem transaction):
  - state goes to S_IDLE immediately and refill clears to 0.
  - every output is 0, counters included.
  - pmem_read/pmem_write drop combinationally with state.
- S_IDLE:
  - all strobes 0.
  - req goes to S_COMPARE next cycle, so the datapath arrays (registered read) have one cycle to present the indexed set.
- S_COMPARE: in_compare_tag=1.
  - req=0 (request withdrawn): go to S_IDLE, no mem_resp.
  - hit, read: mem_resp=1, go to S_IDLE, refill cleared.
  - hit, write: mem_resp=1, load_data=1, load_dirty=1, load_tag=1, load_valid=1, data_in_sel=0, go to S_IDLE.
  - miss with dirty_overall=1: go to S_WRITEBACK.
  - miss with dirty_overall=0: go to S_ALLOCATE.
  - miss while refill=1 is a protocol error: go to S_ALLOCATE again, no lockup requirement beyond retry.
- S_WRITEBACK: write_back_state=1, pmem_write=1.
  - Holds until pmem_resp=1, then goes to S_ALLOCATE.
  - CPU request changes are ignored until completion; the pmem transaction is never aborted except by reset.
- S_ALLOCATE: pmem_read=1, write_back_state=0.
  - On pmem_resp=1 (same cycle): data_in_sel=1, load_data=1, load_tag=1, load_valid=1, refill set to 1, go to S_COMPARE.
- Latency:
  - read hit: mem_resp 2 cycles after request.
  - clean miss: 2 + N_alloc + 1 cycles.
  - dirty miss: additionally + N_wb cycles.
- pmem_resp outside S_WRITEBACK/S_ALLOCATE is ignored.

Optional Feature:
- Macro CACHE_CTRL_PERF_CNT_EN.
- Defined:
  - hit_count increments on a S_COMPARE hit with refill=0.
  - miss_count increments on each S_COMPARE to S_ALLOCATE/S_WRITEBACK transition with refill=0.
  - wb_count increments on S_WRITEBACK exit.
  - All three saturate at 2^CNT_W-1 (no wrap) and clear on reset.
- Undefined: all three ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package (rv32i_types): enum cache_ctrl_state_t {S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE}, 2-bit encoding.
- Sub-module sat_counter #(CNT_W) (clk, rst, inc, count): instantiated three times under the macro.

Test Plan:
- Reset mid-S_WRITEBACK (pmem_write=1), pull rst=0 -> same cycle pmem_write=0, all outputs 0; after release, state S_IDLE.
- mem_read=1, hit_overall=1 in compare -> mem_resp pulses exactly once at cycle 2; load_* all 0; hit_count=1.
- mem_write=1, hit -> mem_resp with load_data/load_dirty/load_tag/load_valid=1 for one cycle; data_in_sel=0.
- Read, miss, dirty_overall=0, pmem_resp after 5 cycles -> pmem_read high 5 cycles, then load_data+data_in_sel=1, re-compare hit, mem_resp; miss_count=1, hit_count=0.
- Read, miss, dirty_overall=1 -> write_back_state=1 + pmem_write until pmem_resp, then S_ALLOCATE; wb_count=1.
- mem_read=mem_write=1 held 10 cycles -> stays S_IDLE, no strobes. With CNT_W=2, 5 hits -> hit_count=3 (saturated).

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the cache controller slice.
// Provides the controller state encoding (2-bit enum).
package rv32i_types;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COMPARE   = 2'd1,
        S_WRITEBACK = 2'd2,
        S_ALLOCATE  = 2'd3
    } cache_ctrl_state_t;

endpackage

// File: rtl/cache_control_fsm_sat_counter.sv
// Saturating up-counter, holds at all-ones instead of wrapping.
// Ports: clk, rst (async active-low), inc, count[CNT_W-1:0].
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/cache_control_fsm.sv
// Sequencing controller for a 2-way, 8-set, 256-bit-line cache.
// Inputs: clk, rst (async active-low), mem_read/mem_write (CPU),
//   hit_overall/miss_overall/dirty_overall (datapath), pmem_resp.
// Outputs: mem_resp, in_compare_tag, load_tag/valid/dirty/data,
//   data_in_sel, write_back_state, pmem_read/pmem_write, and
//   hit_count/miss_count/wb_count (live only with
//   CACHE_CTRL_PERF_CNT_EN defined, otherwise tied to 0).
import rv32i_types::*;

module cache_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic             hit_overall,
    input  logic             miss_overall,
    input  logic             dirty_overall,
    output logic             in_compare_tag,
    output logic             load_tag,
    output logic             load_valid,
    output logic             load_dirty,
    output logic             load_data,
    output logic             data_in_sel,
    output logic             write_back_state,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    cache_ctrl_state_t state, state_n;
    logic refill, refill_n;
    logic req;

    // Both strobes high is treated as no request.
    assign req = mem_read ^ mem_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            refill <= 1'b0;
        end else begin
            state  <= state_n;
            refill <= refill_n;
        end
    end

    always_comb begin
        state_n          = state;
        refill_n         = refill;
        mem_resp         = 1'b0;
        in_compare_tag   = 1'b0;
        load_tag         = 1'b0;
        load_valid       = 1'b0;
        load_dirty       = 1'b0;
        load_data        = 1'b0;
        data_in_sel      = 1'b0;
        write_back_state = 1'b0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req) state_n = S_COMPARE;
            end
            S_COMPARE: begin
                in_compare_tag = 1'b1;
                if (!req) begin
                    state_n  = S_IDLE;
                    refill_n = 1'b0;
                end else if (hit_overall) begin
                    mem_resp = 1'b1;
                    state_n  = S_IDLE;
                    refill_n = 1'b0;
                    if (mem_write) begin
                        load_data  = 1'b1;
                        load_dirty = 1'b1;
                        load_tag   = 1'b1;
                        load_valid = 1'b1;
                    end
                end else if (miss_overall) begin
                    // A miss right after a refill is a datapath
                    // fault; just refetch rather than write back.
                    if (!refill && dirty_overall)
                        state_n = S_WRITEBACK;
                    else
                        state_n = S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                write_back_state = 1'b1;
                pmem_write       = 1'b1;
                if (pmem_resp) state_n = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    data_in_sel = 1'b1;
                    load_data   = 1'b1;
                    load_tag    = 1'b1;
                    load_valid  = 1'b1;
                    refill_n    = 1'b1;
                    state_n     = S_COMPARE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

`ifdef CACHE_CTRL_PERF_CNT_EN
    logic cmp_req;
    logic hit_inc;
    logic miss_inc;
    logic wb_inc;

    assign cmp_req  = (state == S_COMPARE) && req && !refill;
    assign hit_inc  = cmp_req && hit_overall;
    assign miss_inc = cmp_req && !hit_overall && miss_overall;
    assign wb_inc   = (state == S_WRITEBACK) && pmem_resp;

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (wb_inc),
        .count (wb_count)
    );
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_control_fsm.sv
// Vector-table bench for cache_control_fsm.
// One table row per clock; expected outputs go through a queue.
module tb_cache_control_fsm;

    localparam int CW = 2;
`ifdef CACHE_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {mem_resp, cmp, ltag, lvalid, ldirty, ldata, dsel, wbs, prd, pwr}
    localparam logic [9:0] O0   = 10'b0000000000;
    localparam logic [9:0] CMP  = 10'b0100000000;
    localparam logic [9:0] RHIT = 10'b1100000000;
    localparam logic [9:0] WHIT = 10'b1111110000;
    localparam logic [9:0] WB   = 10'b0000000101;
    localparam logic [9:0] AL   = 10'b0000000010;
    localparam logic [9:0] ALR  = 10'b0011011010;

    typedef struct {
        bit         r, rd, wr, h, m, d, p;
        logic [9:0] e;
        bit         chk;
        int         hc, mc, wc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_read = 0, mem_write = 0;
    logic hit_overall = 0, miss_overall = 0, dirty_overall = 0;
    logic pmem_resp = 0;
    logic mem_resp, in_compare_tag, load_tag, load_valid;
    logic load_dirty, load_data, data_in_sel, write_back_state;
    logic pmem_read, pmem_write;
    logic [CW-1:0] hit_count, miss_count, wb_count;

    cache_control_fsm #(.CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_resp         (mem_resp),
        .hit_overall      (hit_overall),
        .miss_overall     (miss_overall),
        .dirty_overall    (dirty_overall),
        .in_compare_tag   (in_compare_tag),
        .load_tag         (load_tag),
        .load_valid       (load_valid),
        .load_dirty       (load_dirty),
        .load_data        (load_data),
        .data_in_sel      (data_in_sel),
        .write_back_state (write_back_state),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_resp        (pmem_resp),
        .hit_count        (hit_count),
        .miss_count       (miss_count),
        .wb_count         (wb_count)
    );

    always #5 clk = ~clk;

    vec_t tbl[$];
    vec_t sb[$];
    int nvec = 0;
    int nerr = 0;

    function automatic vec_t mk(bit r, bit rd, bit wr, bit h,
                                bit m, bit d, bit p,
                                logic [9:0] e);
        vec_t v;
        v.r = r; v.rd = rd; v.wr = wr; v.h = h;
        v.m = m; v.d = d; v.p = p; v.e = e;
        v.chk = 1'b0; v.hc = 0; v.mc = 0; v.wc = 0;
        return v;
    endfunction

    function automatic vec_t mkc(bit r, logic [9:0] e,
                                 int hc, int mc, int wc);
        vec_t v;
        v = mk(r, 0, 0, 0, 0, 0, 0, e);
        v.chk = 1'b1;
        v.hc = PERF ? hc : 0;
        v.mc = PERF ? mc : 0;
        v.wc = PERF ? wc : 0;
        return v;
    endfunction

    initial begin
        vec_t v;
        vec_t x;
        logic [9:0] act;

        // reset
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 1, O0));
        tbl.push_back(mkc(0, O0, 0, 0, 0));
        // read hit
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, O0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, RHIT));
        tbl.push_back(mkc(1, O0, 1, 0, 0));
        // write hit
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, O0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, WHIT));
        tbl.push_back(mkc(1, O0, 2, 0, 0));
        // clean miss, 5-cycle refill
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, O0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, CMP));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, AL));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1, ALR));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, RHIT));
        tbl.push_back(mkc(1, O0, 2, 1, 0));
        // miss again after refill: retry allocate, not counted
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, O0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, CMP));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1, ALR));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, CMP));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1, ALR));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, RHIT));
        tbl.push_back(mkc(1, O0, 2, 2, 0));
        // dirty miss, request wobbles during writeback
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, O0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, CMP));
        tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, WB));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, WB));
        tbl.push_back(mk(1, 1, 1, 0, 1, 1, 0, WB));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, WB));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, AL));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, AL));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1, ALR));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, RHIT));
        tbl.push_back(mkc(1, O0, 2, 3, 1));
        // request withdrawn in compare, then a fresh hit
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, O0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, CMP));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, O0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, RHIT));
        tbl.push_back(mkc(1, O0, 3, 3, 1));
        // read and write both high: no request
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, O0));
        // stray pmem_resp in idle
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, O0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, O0));
        // reset in the middle of a writeback
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, O0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, CMP));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, WB));
        tbl.push_back(mkc(0, O0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, O0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, O0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, O0));
        // five hits saturate a 2-bit hit counter
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, O0));
            tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, RHIT));
        end
        tbl.push_back(mkc(1, O0, 3, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            v = tbl[i];
            rst           = v.r;
            mem_read      = v.rd;
            mem_write     = v.wr;
            hit_overall   = v.h;
            miss_overall  = v.m;
            dirty_overall = v.d;
            pmem_resp     = v.p;
            sb.push_back(v);
            #2;
            x = sb.pop_front();
            act = {mem_resp, in_compare_tag, load_tag, load_valid,
                   load_dirty, load_data, data_in_sel,
                   write_back_state, pmem_read, pmem_write};
            nvec++;
            if (act !== x.e) begin
                nerr++;
                $display("FAIL vec%0d outputs: got %b want %b",
                         i, act, x.e);
            end
            if (x.chk) begin
                nvec++;
                if (int'(hit_count) != x.hc ||
                    int'(miss_count) != x.mc ||
                    int'(wb_count) != x.wc) begin
                    nerr++;
                    $display("FAIL vec%0d counters: got %0d/%0d/%0d want %0d/%0d/%0d",
                             i, hit_count, miss_count, wb_count,
                             x.hc, x.mc, x.wc);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
